// File: rtl/instr_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch stage.
// Build option: define PREFETCH_BYPASS_EN to let a response that arrives at an
// empty queue reach the core in the same cycle.
package instr_prefetch_pkg;

  // Widths shared with the cpu core (word-addressed PC, 32-bit instructions).
  localparam int PC_W          = 11;
  localparam int INSTR_W       = 32;
  localparam int DEFAULT_DEPTH = 4;

  // Word presented on instr whenever no valid entry is available.
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic {
    S_BOOT,
    S_FETCH
  } fetch_state_t;

endpackage

// File: rtl/instr_prefetch_if.sv
// Bus between the prefetch stage, the instruction memory and the cpu core.
// master = prefetch stage, slave = memory/core environment.
interface instr_prefetch_if import instr_prefetch_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]    start_pc;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_rd;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_take;
  logic [CNT_W-1:0]   q_count;

  modport master (
    input  start_pc, redirect, redirect_pc, imem_rdata, instr_take,
    output imem_rd, imem_addr, instr, instr_pc, instr_valid, q_count
  );

  modport slave (
    output start_pc, redirect, redirect_pc, imem_rdata, instr_take,
    input  imem_rd, imem_addr, instr, instr_pc, instr_valid, q_count
  );

endinterface

// File: rtl/instr_prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry register queue with push, pop and flush.
// Flush wins over push and pop; pointers wrap naturally (DEPTH is a power of 2).
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 43
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Queue storage, pointers and occupancy; flush empties by snapping head to tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (i_pop) r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_head];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) r_count <= CNT_W'(DEPTH));

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: issues sequential reads to a synchronous instruction memory,
// queues the returned words and hands them to the core; redirect flushes and
// restarts fetch. Build option PREFETCH_BYPASS_EN adds an empty-queue bypass.
module instr_prefetch import instr_prefetch_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_prefetch_if.master  bus
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + PC_W;

  fetch_state_t        r_state;
  logic [PC_W-1:0]     r_fetch_pc;
  logic [PC_W-1:0]     r_req_pc;
  logic                r_rd_pending;

  logic                w_fetching;
  logic                w_flush;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_q_valid;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W:0]      w_inflight;
  logic [ENTRY_W-1:0]  w_head;

  assign w_fetching = (r_state == S_FETCH);
  assign w_flush    = w_fetching & bus.redirect;
  assign w_q_valid  = (w_count != '0);

  // The outstanding read reserves a slot, so a full queue blocks issue even while popping.
  assign w_inflight = {1'b0, w_count} + {{CNT_W{1'b0}}, r_rd_pending};
  assign w_issue    = w_fetching & ~bus.redirect & (w_inflight < (CNT_W+1)'(DEPTH));
  assign w_pop      = bus.instr_take & w_q_valid & ~w_flush;

`ifdef PREFETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass = r_rd_pending & ~w_flush & ~w_q_valid;
  assign w_push   = r_rd_pending & ~w_flush & ~(w_bypass & bus.instr_take);
`else
  assign w_push   = r_rd_pending & ~w_flush;
`endif

  assign bus.imem_rd   = w_issue;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.q_count   = w_count;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({bus.imem_rdata, r_req_pc}),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // Boot/fetch FSM with fetch PC, outstanding-read flag and the PC of that read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_fetch_pc   <= '0;
      r_req_pc     <= '0;
      r_rd_pending <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_fetch_pc   <= bus.start_pc;
          r_rd_pending <= 1'b0;
          r_state      <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.redirect) begin
            r_fetch_pc   <= bus.redirect_pc;
            r_rd_pending <= 1'b0;
          end else begin
            r_rd_pending <= w_issue;
            if (w_issue) begin
              r_fetch_pc <= r_fetch_pc + PC_W'(1);
              r_req_pc   <= r_fetch_pc;
            end
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // Head-of-queue presentation; the bypass build can substitute the arriving word.
  always_comb begin
    bus.instr_valid = w_q_valid;
    bus.instr       = w_q_valid ? w_head[ENTRY_W-1:PC_W] : NOP_INSTR;
    bus.instr_pc    = w_q_valid ? w_head[PC_W-1:0] : '0;
`ifdef PREFETCH_BYPASS_EN
    if (w_bypass) begin
      bus.instr_valid = 1'b1;
      bus.instr       = bus.imem_rdata;
      bus.instr_pc    = r_req_pc;
    end
`endif
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed testbench for instr_prefetch: boot, streaming, redirect, redirect
// colliding with take and a returning word, PC wrap, and reset mid-run.
// Honours PREFETCH_BYPASS_EN for the expected issue-to-valid latency.
module tb_instr_prefetch;
  import instr_prefetch_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

`ifdef PREFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  instr_prefetch_if bus ();

  instr_prefetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address so any word identifies its PC.
  function automatic logic [31:0] memWord(input logic [10:0] pc);
    return {8'hA5, 13'h0, pc};
  endfunction

  // Synchronous instruction memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_rdata <= memWord(bus.imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic take, input logic redir, input logic [10:0] rpc);
    bus.instr_take  = take;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_imem_rd"},     32'(bus.imem_rd),     32'd0);
    checkOutput({pfx, "_imem_addr"},   32'(bus.imem_addr),   32'd0);
    checkOutput({pfx, "_instr"},       32'(bus.instr),       32'd0);
    checkOutput({pfx, "_instr_pc"},    32'(bus.instr_pc),    32'd0);
    checkOutput({pfx, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    checkOutput({pfx, "_q_count"},     32'(bus.q_count),     32'd0);
  endtask

  // Waits (bounded) for instr_valid and returns how many cycles it took.
  task automatic waitValid(output int n);
    n = 0;
    while (!bus.instr_valid && n < 8) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int            n;
    logic [10:0]   ep;

    total = 0;
    bad   = 0;
    bus.start_pc    = 11'h010;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_take  = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    checkAllZero("reset");

    // Boot with no consumer: four sequential reads, then backpressure
    rst_n = 1'b1;
    tick();
    checkOutput("boot_rd0",   32'(bus.imem_rd),   32'd1);
    checkOutput("boot_addr0", 32'(bus.imem_addr), 32'h010);
    for (int i = 1; i < 4; i++) begin
      tick();
      checkOutput("boot_rd",   32'(bus.imem_rd),   32'd1);
      checkOutput("boot_addr", 32'(bus.imem_addr), 32'h010 + 32'(i));
    end
    tick();
    checkOutput("boot_stall_rd", 32'(bus.imem_rd), 32'd0);
    checkOutput("boot_count3",   32'(bus.q_count), 32'd3);
    tick();
    checkOutput("boot_count4",   32'(bus.q_count),     32'd4);
    checkOutput("boot_full_rd",  32'(bus.imem_rd),     32'd0);
    checkOutput("boot_valid",    32'(bus.instr_valid), 32'd1);
    checkOutput("boot_instr_pc", 32'(bus.instr_pc),    32'h010);
    checkOutput("boot_instr",    bus.instr,            memWord(11'h010));

    // Streaming: one instruction per cycle, in order, no gaps
    applyStimulus(1'b1, 1'b0, 11'h000);
    for (int i = 0; i < 8; i++) begin
      ep = 11'h010 + 11'(i);
      checkOutput("stream_valid", 32'(bus.instr_valid), 32'd1);
      checkOutput("stream_pc",    32'(bus.instr_pc),    32'(ep));
      checkOutput("stream_instr", bus.instr,            memWord(ep));
      tick();
    end

    // Redirect with take high and a word returning: flush, no pop, no push
    applyStimulus(1'b1, 1'b1, 11'h200);
    checkOutput("redir_rd_blocked", 32'(bus.imem_rd), 32'd0);
    tick();
    checkOutput("redir_count", 32'(bus.q_count),     32'd0);
    checkOutput("redir_valid", 32'(bus.instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 11'h000);
    checkOutput("redir_rd",   32'(bus.imem_rd),   32'd1);
    checkOutput("redir_addr", 32'(bus.imem_addr), 32'h200);
    waitValid(n);
    checkOutput("redir_latency", 32'(n),            32'(LAT));
    checkOutput("redir_pc",      32'(bus.instr_pc), 32'h200);
    checkOutput("redir_instr",   bus.instr,         memWord(11'h200));

    // PC wrap across 7FF -> 000
    applyStimulus(1'b1, 1'b1, 11'h7FE);
    tick();
    applyStimulus(1'b1, 1'b0, 11'h000);
    waitValid(n);
    checkOutput("wrap_latency", 32'(n), 32'(LAT));
    ep = 11'h7FE;
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrap_valid", 32'(bus.instr_valid), 32'd1);
      checkOutput("wrap_pc",    32'(bus.instr_pc),    32'(ep));
      ep = ep + 11'd1;
      tick();
    end

    // Fill to three entries with one read outstanding, then reset mid-run
    applyStimulus(1'b0, 1'b1, 11'h100);
    tick();
    applyStimulus(1'b0, 1'b0, 11'h000);
    n = 0;
    while (bus.q_count != 3 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("fill_cycles",  32'(n),              32'd4);
    checkOutput("fill_count",   32'(bus.q_count),    32'd3);
    checkOutput("fill_rd_stop", 32'(bus.imem_rd),    32'd0);
    checkOutput("fill_head_pc", 32'(bus.instr_pc),   32'h100);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    tick();

    // Release with a redirect pending during boot: it must be ignored
    bus.start_pc    = 11'h040;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 11'h300;
    rst_n           = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 11'h000);
    checkOutput("restart_rd",   32'(bus.imem_rd),   32'd1);
    checkOutput("restart_addr", 32'(bus.imem_addr), 32'h040);
    waitValid(n);
    checkOutput("restart_latency", 32'(n),            32'(LAT));
    checkOutput("restart_pc",      32'(bus.instr_pc), 32'h040);
    checkOutput("restart_instr",   bus.instr,         memWord(11'h040));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
